// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side stream adapter:
//   FIFO_RD_LATENCY    - read-port latency of the core FIFO (cycles)
//   FIFO_RD_SKID_DEPTH - number of local skid entries behind the read port
//   occ_t              - occupancy count type (0..2)
//   ptr_inc            - wrap-around increment for a 1-bit entry pointer
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_RD_LATENCY    = 1;
    localparam int FIFO_RD_SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // With two entries the pointer simply toggles; 1 wraps to 0.
    function automatic logic ptr_inc(input logic ptr);
        return ~ptr;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry skid storage with head/tail pointers and an occupancy count.
//   clk_i        in   clock, rising edge
//   rst_n_i      in   asynchronous active-low reset
//   clear_i      in   synchronous clear of pointers and count (wins over push/pop)
//   push_i       in   write push_data_i at tail
//   push_data_i  in   WIDTH write data
//   pop_i        in   advance head
//   head_data_o  out  WIDTH entry at head
//   count_o      out  number of valid entries (0..2)
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [FIFO_RD_SKID_DEPTH];
    logic             head_q;
    logic             tail_q;
    occ_t             count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < FIFO_RD_SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            // Entry contents are left alone; only the bookkeeping is discarded.
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= ptr_inc(tail_q);
            end
            if (pop_i) begin
                head_q <= ptr_inc(head_q);
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Turns the 1-cycle-latency read port of the core FIFO into a valid/ready
// stream master backed by a 2-entry skid buffer; sustains one word per cycle.
//   clk_i         in   clock, rising edge
//   rst_n_i       in   asynchronous active-low reset
//   fifo_rdata_i  in   WIDTH FIFO read data, valid the cycle after an accepted read
//   fifo_empty_i  in   FIFO empty flag
//   fifo_rd_en_o  out  FIFO read request
//   flush_i       in   discard buffered and in-flight words (FIFO untouched)
//   m_valid_o     out  stream valid
//   m_data_o      out  WIDTH stream data (head of skid buffer)
//   m_ready_i     in   consumer ready
// Build option FIFO_RD_STREAM_BYPASS_EN: when the buffer is empty the arriving
// word is presented on the stream in its arrival cycle, cutting latency by one.
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic             flush_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i
);

    generate
        if (BUF_DEPTH != FIFO_RD_SKID_DEPTH) begin : g_depth_check
            $error("fifo_rd_stream: BUF_DEPTH must be 2");
        end
        if (FIFO_RD_LATENCY != 1) begin : g_latency_check
            $error("fifo_rd_stream: only a 1-cycle FIFO read latency is supported");
        end
    endgenerate

    logic             inflight_q;
    occ_t             buf_cnt;
    occ_t             occ;
    logic             m_fire;
    logic             arrival;
    logic             push;
    logic             pop;
    logic             buf_empty;
    logic [WIDTH-1:0] head_data;

    // Words already owned by this block: buffered plus the one on its way.
    assign occ       = buf_cnt + {1'b0, inflight_q};
    assign buf_empty = (buf_cnt == 2'd0);
    assign m_fire    = m_valid_o & m_ready_i;

    // m_ready_i reaches fifo_rd_en_o combinationally: when full, a pop this
    // cycle frees the slot the new word will need two edges from now.
    assign fifo_rd_en_o = ~fifo_empty_i & ~flush_i &
                          ((occ < 2'd2) | ((occ == 2'd2) & m_fire));

    assign arrival = inflight_q & ~flush_i;

`ifdef FIFO_RD_STREAM_BYPASS_EN
    logic bypass;

    assign bypass    = buf_empty & inflight_q;
    assign m_valid_o = ~buf_empty | inflight_q;
    assign m_data_o  = bypass ? fifo_rdata_i : head_data;
    // A bypassed word consumed in its arrival cycle never touches the buffer.
    assign push      = arrival & ~(bypass & m_ready_i);
    assign pop       = m_fire & ~buf_empty;
`else
    assign m_valid_o = ~buf_empty;
    assign m_data_o  = head_data;
    assign push      = arrival;
    assign pop       = m_fire;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= 1'b0;
        end else begin
            // fifo_rd_en_o is already forced low during a flush.
            inflight_q <= fifo_rd_en_o;
        end
    end

    fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clear_i     (flush_i),
        .push_i      (push),
        .push_data_i (fifo_rdata_i),
        .pop_i       (pop),
        .head_data_o (head_data),
        .count_o     (buf_cnt)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int W = 32;
`ifdef FIFO_RD_STREAM_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic [W-1:0] fifo_rdata_i;
    logic         fifo_empty_i;
    logic         fifo_rd_en_o;
    logic         flush_i = 1'b0;
    logic         m_valid_o;
    logic [W-1:0] m_data_o;
    logic         m_ready_i = 1'b0;

    fifo_rd_stream #(.WIDTH(W), .BUF_DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .flush_i      (flush_i),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model: 1-cycle registered read port ----------------
    logic [W-1:0] fifo_mem [256];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    bit           empty_mask = 1'b0;

    assign fifo_empty_i = (wr_ptr == rd_ptr) || empty_mask;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fifo_rdata_i <= '0;
            rd_ptr       <= wr_ptr;   // FIFO shares the reset
        end else if (fifo_rd_en_o && !fifo_empty_i) begin
            fifo_rdata_i <= fifo_mem[rd_ptr & 255];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic fifo_push(input logic [W-1:0] d);
        fifo_mem[wr_ptr & 255] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // ---------------- Stream model and per-cycle comparison ----------------
    // Every word taken from the FIFO is owed to the consumer, in order, becoming
    // visible LAT cycles after its read cycle; a flush forgets all owed words.
    typedef struct {
        logic [W-1:0] d;
        int           c;
    } ent_t;

    ent_t         sb[$];
    logic [W-1:0] fire_log[$];
    int           cyc = 0;
    int           rd_n = 0, fire_n = 0;
    int           first_rd = -1, first_valid = -1;
    int           rd_run = 0, rd_run_max = 0, fire_run = 0, fire_run_max = 0;

    always @(negedge clk_i) begin
        bit exp_valid, exp_rd, fire;
        int occ;
        if (!rst_n_i) begin
            sb.delete();
        end else begin
            occ       = sb.size();
            exp_valid = (occ > 0) && (cyc - sb[0].c >= LAT);
            fire      = exp_valid && m_ready_i && !flush_i;
            exp_rd    = !fifo_empty_i && !flush_i &&
                        ((occ < 2) || (occ == 2 && exp_valid && m_ready_i));
            check("rd_en", 64'(fifo_rd_en_o), 64'(exp_rd));
            check("m_valid", 64'(m_valid_o), 64'(exp_valid));
            if (exp_valid) check("m_data", 64'(m_data_o), 64'(sb[0].d));

            if (fifo_rd_en_o) begin rd_run++; if (rd_run > rd_run_max) rd_run_max = rd_run; end
            else rd_run = 0;
            if (fire) begin fire_run++; if (fire_run > fire_run_max) fire_run_max = fire_run; end
            else fire_run = 0;
            if (m_valid_o && first_valid < 0) first_valid = cyc;

            if (flush_i) begin
                sb.delete();
            end else begin
                if (fire) begin
                    fire_log.push_back(sb[0].d);
                    fire_n++;
                    void'(sb.pop_front());
                end
                if (fifo_rd_en_o && !fifo_empty_i) begin
                    sb.push_back('{fifo_mem[rd_ptr & 255], cyc});
                    rd_n++;
                    if (first_rd < 0) first_rd = cyc;
                end
            end
            check("occ_le_2", 64'(sb.size() <= 2), 64'(1));
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_stats();
        fire_log.delete();
        rd_n = 0; fire_n = 0; first_rd = -1; first_valid = -1;
        rd_run_max = 0; fire_run_max = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        rst_n_i = 1'b1;
        tick(1);

        // ---- Reset with a word buffered ----
        m_ready_i = 1'b0;
        fifo_push(32'h0000_0011);
        tick(4);
        check("pre_reset_valid", 64'(m_valid_o), 64'(1));
        check("pre_reset_data", 64'(m_data_o), 64'h11);
        rst_n_i = 1'b0;
        #1;
        check("reset_rd_en", 64'(fifo_rd_en_o), 64'(0));
        check("reset_valid", 64'(m_valid_o), 64'(0));
        check("reset_data", 64'(m_data_o), 64'(0));
        tick(2);
        rst_n_i = 1'b1;
        tick(3);
        check("post_reset_valid", 64'(m_valid_o), 64'(0));
        check("post_reset_rd_en", 64'(fifo_rd_en_o), 64'(0));

        // ---- Single word ----
        clear_stats();
        m_ready_i = 1'b1;
        fifo_push(32'hA5A5_A5A5);
        tick(6);
        check("single_reads", 64'(rd_n), 64'(1));
        check("single_fires", 64'(fire_n), 64'(1));
        check("single_data", 64'(fire_log[0]), 64'hA5A5_A5A5);
        check("single_latency", 64'(first_valid - first_rd), 64'(LAT));
        check("single_idle", 64'(m_valid_o), 64'(0));

        // ---- Throughput ----
        clear_stats();
        for (int i = 1; i <= 4; i++) fifo_push(W'(i));
        tick(8);
        check("thru_fires", 64'(fire_n), 64'(4));
        check("thru_rd_run", 64'(rd_run_max), 64'(4));
        check("thru_fire_run", 64'(fire_run_max), 64'(4));
        for (int i = 0; i < 4; i++) check("thru_data", 64'(fire_log[i]), 64'(i + 1));

        // ---- Backpressure ----
        clear_stats();
        m_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) fifo_push(W'(i));
        tick(5);
        check("bp_reads_stalled", 64'(rd_n), 64'(2));
        check("bp_head", 64'(m_data_o), 64'(1));
        check("bp_rd_en_low", 64'(fifo_rd_en_o), 64'(0));
        m_ready_i = 1'b1;
        tick(12);
        check("bp_fires", 64'(fire_n), 64'(6));
        for (int i = 0; i < 6; i++) check("bp_data", 64'(fire_log[i]), 64'(i + 1));

        // ---- Flush on the arrival cycle ----
        clear_stats();
        fifo_push(32'h0000_0055);
        tick(1);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        check("flush_valid_after", 64'(m_valid_o), 64'(0));
        fifo_push(32'h0000_0066);
        tick(6);
        check("flush_fires", 64'(fire_n), 64'(1));
        check("flush_resume_data", 64'(fire_log[0]), 64'h66);

        // ---- Empty toggling with random ready ----
        clear_stats();
        for (int i = 0; i < 20; i++) fifo_push(W'(32'h200 + i));
        for (int k = 0; k < 80; k++) begin
            empty_mask = ~empty_mask;
            m_ready_i  = 1'($urandom_range(0, 1));
            tick(1);
        end
        empty_mask = 1'b0;
        m_ready_i  = 1'b1;
        tick(10);
        check("toggle_fires", 64'(fire_n), 64'(20));
        for (int i = 0; i < 20; i++) check("toggle_data", 64'(fire_log[i]), 64'(32'h200 + i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
